rvfi_seq_monitor: RTL
=====================

// Module: rvfi_seq_monitor
// PURPOSE
//  Synthesizable RVFI retirement-sequence monitor for formal and sim benches around MR1-class cores.
//  Generalises the single-channel per-instruction ISA check with cross-instruction checks over NRET
//  retire channels: order continuity, PC continuity, halt discipline and a liveness watchdog.
//  Counts retires and traps. Instantiated beside the core; outputs feed assert() or bench scoreboards.
// PARAMETERS
//  NRET     1   retire channels per cycle (1..4)
//  XLEN     32  PC width
//  TIMEOUT  64  max consecutive cycles without a retire before err_live; 0 disables the watchdog
//  CNT_W    32  width of retire_cnt and trap_cnt
// PORTS
//  clk               in   1         rising-edge clock
//  reset             in   1         synchronous, active-low reset
//  rvfi_valid        in   NRET      per-channel retire strobe
//  rvfi_order        in   NRET*64   per-channel retire index
//  rvfi_pc_rdata     in   NRET*XLEN per-channel PC of the retired insn
//  rvfi_pc_wdata     in   NRET*XLEN per-channel next PC
//  rvfi_trap         in   NRET      per-channel trap flag
//  rvfi_halt         in   NRET      per-channel halt flag
//  err_order         out  1         sticky: order gap or non-contiguous valid channels
//  err_pc            out  1         sticky: pc_rdata differs from the expected PC
//  err_halt          out  1         sticky: retire seen after halt
//  err_live          out  1         sticky: watchdog expired
//  err_any           out  1         OR of the four error flags (combinational)
//  err_order_val     out  64        expected order at the first error (captured once)
//  retire_cnt        out  CNT_W     retired insns since reset, saturating
//  trap_cnt          out  CNT_W     retired insns with trap=1, saturating
//  state             out  2         0 IDLE, 1 RUN, 2 HALTED
// BEHAVIOUR
//  Reset (reset==0 at posedge): all err_* = 0, err_order_val = 0, counters = 0, state = IDLE,
//   exp_order = 0, exp_pc invalid, watchdog = 0. Reset mid-operation discards all history.
//  Channel k means slice [k*W +: W]. Valid channels must be contiguous from channel 0;
//   valid[k] && !valid[k-1] sets err_order.
//  Order check: valid channel k must carry rvfi_order == exp_order + k.
//   Then exp_order += popcount(valid), with 64-bit wrap.
//  PC check, across cycles: if exp_pc is valid, channel 0 pc_rdata must equal exp_pc.
//   exp_pc is then loaded from pc_wdata of the highest valid channel.
//  PC check, within a cycle: valid channel k>0 must have pc_rdata == pc_wdata of channel k-1.
//  Trap and PC: a retire with trap=1 still updates exp_pc from its pc_wdata (handler target).
//  All checks use pre-update register values. Updates apply at the same posedge.
//  FSM:
//   IDLE -> RUN on any valid.
//   RUN -> HALTED when any valid channel has halt=1. Channels above it in the same cycle set err_halt.
//   HALTED: any valid sets err_halt. Only reset exits HALTED.
//  Counters: retire_cnt += popcount(valid); trap_cnt += popcount(valid & trap).
//   Both saturate at all-ones and keep counting in every state.
//  Watchdog (TIMEOUT>0):
//   Counts cycles in IDLE or RUN with valid == 0; clears on any valid.
//   Sets err_live when the count reaches TIMEOUT. Frozen and cleared in HALTED.
//  Error flags are sticky until reset. Multiple errors may set in one cycle.
//  err_order_val captures exp_order in the cycle the first error of any kind is detected.
//   Later errors do not overwrite it.
//  Latency: errors and counters are registered, visible 1 cycle after the offending input.
//   err_any is combinational from the registered flags.
//  X on inputs of invalid channels is ignored; only valid-qualified slices are used.
// TESTING
//  1. NRET=1; 5 retires, orders 0..4, pc 0,4,8,12,16 with wdata = pc+4
//     -> no errors, retire_cnt=5, state=RUN.
//  2. NRET=1; orders 0,1,3 -> err_order set in the cycle after order 3, err_order_val=2; stays set.
//  3. NRET=1; retire pc_rdata=0x0/wdata=0x4, then pc_rdata=0x8 -> err_pc=1, err_order=0.
//  4. NRET=2; valid=2'b10 -> err_order. Separately: valid=2'b11, orders 0,1, pc 0x0->0x4, 0x4->0x8
//     -> no error, retire_cnt=2.
//  5. TIMEOUT=4; one retire then 4 idle cycles -> err_live=1 after the 4th idle cycle.
//     Same stimulus with halt=1 on the retire -> err_live stays 0, state=HALTED.
//  6. Halt on order 2, then a valid at order 3 -> err_halt=1. Pulse reset low 1 cycle
//     -> all flags 0, state=IDLE, retire_cnt=0.

Source files
------------

// File: rtl/rvfi_seq_monitor.sv
// Cross-instruction RVFI retirement checker: order/PC continuity, halt discipline,
// liveness watchdog, plus saturating retire and trap counters over NRET channels.
module rvfi_seq_monitor #(
   parameter int NRET    = 1,
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NRET-1:0]        rvfi_valid,
   input  logic [NRET*64-1:0]     rvfi_order,
   input  logic [NRET*XLEN-1:0]   rvfi_pc_rdata,
   input  logic [NRET*XLEN-1:0]   rvfi_pc_wdata,
   input  logic [NRET-1:0]        rvfi_trap,
   input  logic [NRET-1:0]        rvfi_halt,
   output logic                   err_order,
   output logic                   err_pc,
   output logic                   err_halt,
   output logic                   err_live,
   output logic                   err_any,
   output logic [63:0]            err_order_val,
   output logic [CNT_W-1:0]       retire_cnt,
   output logic [CNT_W-1:0]       trap_cnt,
   output logic [1:0]             state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t              state_reg, state_next;
   logic                err_order_reg, err_pc_reg, err_halt_reg, err_live_reg;
   logic [63:0]         err_order_val_reg;
   logic [CNT_W-1:0]    retire_cnt_reg, trap_cnt_reg;
   logic [63:0]         exp_order_reg;
   logic [XLEN-1:0]     exp_pc_reg;
   logic                exp_pc_valid_reg;

   logic [NRET-1:0]     order_bad, gap_bad, pc_bad;
   logic [2:0]          ret_pop, trap_pop;
   logic                halt_seen, halt_above;
   logic [XLEN-1:0]     pc_last;
   logic                any_valid;
   logic                ord_err, pc_err, halt_err, live_hit, new_err;

   assign any_valid = |rvfi_valid;

   // Per-channel order, contiguity and PC-link checks against pre-update state.
   genvar gi;
   generate
      for (gi = 0; gi < NRET; gi++) begin : g_ch
         logic [63:0]     ord_k;
         logic [XLEN-1:0] rd_k;
         assign ord_k = rvfi_order[gi*64 +: 64];
         assign rd_k  = rvfi_pc_rdata[gi*XLEN +: XLEN];
         assign order_bad[gi] = rvfi_valid[gi] && (ord_k != exp_order_reg + 64'(gi));
         if (gi == 0) begin : g_first
            assign gap_bad[gi] = 1'b0;
            assign pc_bad[gi]  = rvfi_valid[gi] && exp_pc_valid_reg && (rd_k != exp_pc_reg);
         end else begin : g_rest
            assign gap_bad[gi] = rvfi_valid[gi] && !rvfi_valid[gi-1];
            assign pc_bad[gi]  = rvfi_valid[gi] && rvfi_valid[gi-1] &&
                                 (rd_k != rvfi_pc_wdata[(gi-1)*XLEN +: XLEN]);
         end
      end
   endgenerate

   always_comb begin
      ret_pop    = '0;
      trap_pop   = '0;
      halt_seen  = 1'b0;
      halt_above = 1'b0;
      pc_last    = exp_pc_reg;
      for (int k = 0; k < NRET; k++) begin
         if (rvfi_valid[k]) begin
            ret_pop = ret_pop + 3'd1;
            if (rvfi_trap[k]) trap_pop = trap_pop + 3'd1;
            if (halt_seen) halt_above = 1'b1;
            if (rvfi_halt[k]) halt_seen = 1'b1;
            pc_last = rvfi_pc_wdata[k*XLEN +: XLEN];
         end
      end
   end

   generate
      if (TIMEOUT > 0) begin : g_wd
         logic [WD_W-1:0] wd_reg, wd_next;
         always_comb begin
            wd_next = wd_reg;
            if (state_reg == ST_HALTED || any_valid)
               wd_next = '0;
            else if (wd_reg != WD_W'(TIMEOUT))
               wd_next = wd_reg + WD_W'(1);
         end
         always_ff @(posedge clk) begin
            if (!reset) wd_reg <= '0;
            else        wd_reg <= wd_next;
         end
         assign live_hit = (wd_next == WD_W'(TIMEOUT));
      end else begin : g_no_wd
         assign live_hit = 1'b0;
      end
   endgenerate

   assign ord_err  = |order_bad || |gap_bad;
   assign pc_err   = |pc_bad;
   assign halt_err = (state_reg == ST_HALTED) ? any_valid : halt_above;
   assign new_err  = ord_err || pc_err || halt_err || live_hit;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (any_valid) state_next = halt_seen ? ST_HALTED : ST_RUN;
         ST_RUN:    if (halt_seen) state_next = ST_HALTED;
         ST_HALTED: state_next = ST_HALTED;
         default:   state_next = ST_IDLE;
      endcase
   end

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [2:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-2){1'b0}}, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg         <= ST_IDLE;
         err_order_reg     <= 1'b0;
         err_pc_reg        <= 1'b0;
         err_halt_reg      <= 1'b0;
         err_live_reg      <= 1'b0;
         err_order_val_reg <= '0;
         retire_cnt_reg    <= '0;
         trap_cnt_reg      <= '0;
         exp_order_reg     <= '0;
         exp_pc_reg        <= '0;
         exp_pc_valid_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         err_order_reg <= err_order_reg | ord_err;
         err_pc_reg    <= err_pc_reg | pc_err;
         err_halt_reg  <= err_halt_reg | halt_err;
         err_live_reg  <= err_live_reg | live_hit;
         // Only the first error event records where the sequence went wrong.
         if (!err_any && new_err) err_order_val_reg <= exp_order_reg;
         retire_cnt_reg <= sat_add(retire_cnt_reg, ret_pop);
         trap_cnt_reg   <= sat_add(trap_cnt_reg, trap_pop);
         if (any_valid) begin
            exp_order_reg    <= exp_order_reg + 64'(ret_pop);
            exp_pc_reg       <= pc_last;
            exp_pc_valid_reg <= 1'b1;
         end
      end
   end

   assign err_order     = err_order_reg;
   assign err_pc        = err_pc_reg;
   assign err_halt      = err_halt_reg;
   assign err_live      = err_live_reg;
   assign err_any       = err_order_reg | err_pc_reg | err_halt_reg | err_live_reg;
   assign err_order_val = err_order_val_reg;
   assign retire_cnt    = retire_cnt_reg;
   assign trap_cnt      = trap_cnt_reg;
   assign state         = state_reg;

endmodule
